uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver for the 64-bit packet link; the counterpart of the chip's UART transmitter. It recovers LSB-first framed words (start bit 0, WIDTH data bits, stop bit 1) from a line sampled at 2x the baud rate. It checks odd parity over the full word and the stop bit, then presents the word through a valid/ack handshake to the packet-parsing logic (configuration write/read decoder and FIFO). Packet fields are not interpreted here.

## Interface
- WIDTH, 64, data bits per frame; bit WIDTH-1 is the odd-parity bit
- txclk  input  1  sampling clock, exactly 2x line baud rate
- reset_n  input  1  asynchronous, active-low reset
- rx_in  input  1  serial line, idle high, asynchronous to txclk
- rx_enable  input  1  clock gate; low freezes all state and outputs
- rx_data_ack  input  1  consumer accepts rx_data; clears rx_data_valid
- rx_data  output  WIDTH  last received word
- rx_data_valid  output  1  high from word load until acked
- rx_parity_err  output  1  word in rx_data has even ones-count
- rx_frame_err  output  1  stop bit of word in rx_data sampled 0
- rx_overrun  output  1  word loaded while previous was still unacked
- rx_busy  output  1  high in any state other than IDLE

## Operation
- rx_in passes through a 2-flop synchronizer (sync1, sync2); the FSM uses only sync2.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. phase is a 1-bit counter; bit_cnt is 7 bits.
- IDLE: when sync2==0, go to START.
- START: confirms the start bit one cycle later. If sync2==0, go to DATA with phase=0 and bit_cnt=0. Otherwise it is a glitch: return to IDLE with no flags set.
- DATA: phase toggles each cycle. When phase==1, shift sync2 into the MSB of shift register sr (shift right) and increment bit_cnt. After the WIDTH-th sample, go to STOP with phase=0. After the last shift, sr[0] holds the first bit received.
- STOP: samples sync2 on the second cycle. That same edge:
  - loads rx_data<=sr and sets rx_data_valid=1;
  - sets rx_parity_err = ~(^sr) and rx_frame_err = ~sync2;
  - sets rx_overrun = rx_data_valid & ~rx_data_ack.
  Next state is IDLE if sync2==1, else WAIT_HIGH.
- WAIT_HIGH: stay until sync2==1, then go to IDLE. A held-low break line yields exactly one frame-error word and does not re-trigger.
- Handshake:
  - rx_data_ack high with rx_data_valid high clears valid at the next edge.
  - ack in the same cycle as a STOP load: the new word wins, valid stays 1, overrun=0.
  - ack while valid is low is ignored.
- Error flags and overrun describe the word currently in rx_data. They hold until the next load or reset; ack does not clear them.
- rx_enable low: every register, including the synchronizer, holds its value. Bits arriving during that time are lost.
- Reset mid-frame aborts the frame: no word is loaded, and the FSM restarts in IDLE.

## Timing
- Reset values:
  - rx_data=0, rx_data_valid=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, rx_busy=0;
  - sync1=sync2=1, state=IDLE, sr=0, bit_cnt=0, phase=0.
- E0 is the first edge that captures rx_in=0 into sync1.
  - sync2=0 at E1.
  - START entered at E2; DATA entered at E3.
  - Data bit i sampled at E5+2i; bit WIDTH-1 at E131.
  - Stop bit sampled and word loaded at E133; rx_data_valid high after E133.
- Each sample falls in the second half of its bit cell. The receiver tolerates the transmitter's stop-bit extension and idle-high gaps of any length.
- Back-to-back frames: IDLE is reached at E134, so a start bit beginning one bit time after the stop bit is detected.
- rx_busy is a registered state decode: high from E2 until return to IDLE.

## Test plan
- Clean frame 64'h8000_0000_0000_00FF (9 ones) -> rx_data matches, valid at E133, parity_err=0, frame_err=0, overrun=0.
- Frame 64'h0000_0000_0000_0003 (even ones) -> parity_err=1, word still loaded, valid=1.
- One-cycle low glitch on idle line -> START aborts to IDLE, no valid, rx_busy drops after 2 cycles.
- Stop bit driven 0, line held low 300 cycles -> frame_err=1, exactly one valid, FSM in WAIT_HIGH until line high, then next frame 64'h1 received cleanly.
- Two back-to-back frames without ack -> second load sets overrun=1, rx_data = second word. Repeat with ack on the load edge -> overrun=0, valid=1.
- reset_n pulsed low at bit 30, and rx_enable low for 10 cycles mid-idle -> all outputs return to reset values, next frame 64'hA000_0000_0000_0001 decodes correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Serial receiver for the 64-bit packet link: recovers LSB-first framed words from a
// line sampled at 2x baud, checks odd parity and stop bit, and hands the word over valid/ack.
module uart_rx #(
  parameter int WIDTH = 64
) (
  input  logic             txclk,
  input  logic             reset_n,
  input  logic             rx_in,
  input  logic             rx_enable,
  input  logic             rx_data_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_data_valid,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_overrun,
  output logic             rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [6:0] LAST_BIT = 7'(WIDTH - 1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             phase;
  logic [6:0]       bit_cnt;
  logic [WIDTH-1:0] sr;

  // NOTE: every register here is sequential state, so it is assigned only with <=;
  // that keeps the later STOP load able to override the earlier ack clear in the same edge.
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      state         <= IDLE;
      phase         <= 1'b0;
      bit_cnt       <= '0;
      // NOTE: the shift register is datapath, but it is cleared too so a word
      // loaded after a reset never carries bits from before it.
      sr            <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
    end else if (rx_enable) begin
      sync1 <= rx_in;
      sync2 <= sync1;

      if (rx_data_valid && rx_data_ack) begin
        rx_data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!sync2) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (!sync2) begin
            state   <= DATA;
            phase   <= 1'b0;
            bit_cnt <= '0;
          end else begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        DATA: begin
          phase <= ~phase;
          if (phase) begin
            sr      <= {sync2, sr[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 7'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              phase <= 1'b0;
            end
          end
        end

        STOP: begin
          phase <= ~phase;
          if (phase) begin
            // A load beats a same-cycle ack: the new word is what the consumer sees next.
            rx_data       <= sr;
            rx_data_valid <= 1'b1;
            rx_parity_err <= ~(^sr);
            rx_frame_err  <= ~sync2;
            rx_overrun    <= rx_data_valid & ~rx_data_ack;
            phase         <= 1'b0;
            if (sync2) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          // A held-low break must not look like a new start bit.
          if (sync2) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed corner frames plus random frames, checked against a
// word-level model (expected data, parity from ones-count, stop bit, handshake state).
module tb_uart_rx;

  logic        txclk = 1'b0;
  logic        reset_n;
  logic        rx_in;
  logic        rx_enable;
  logic        rx_data_ack;
  logic [63:0] rx_data;
  logic        rx_data_valid;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic        rx_busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: whether the consumer currently holds an unacked word.
  logic        m_valid = 1'b0;

  uart_rx #(.WIDTH(64)) dut (
    .txclk        (txclk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .rx_enable    (rx_enable),
    .rx_data_ack  (rx_data_ack),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 txclk = ~txclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One bit cell is two sampling clocks; called and returns just after a negedge.
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (2) @(negedge txclk);
  endtask

  task automatic send_frame(input logic [63:0] w, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 64; i++) drive_bit(w[i]);
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  // Called right after the stop cell ends; the word must appear exactly two edges later.
  task automatic check_load(input logic [63:0] w, input logic stop, input logic ack_at_load);
    logic exp_ovr;
    @(posedge txclk);
    #1;
    if (!m_valid) check("valid_before_load", {63'd0, rx_data_valid}, 64'd0);
    if (ack_at_load) begin
      @(negedge txclk);
      rx_data_ack = 1'b1;
    end
    @(posedge txclk);
    #1;
    rx_data_ack = 1'b0;
    exp_ovr = m_valid && !ack_at_load;
    m_valid = 1'b1;
    check("data",       rx_data, w);
    check("valid",      {63'd0, rx_data_valid}, 64'd1);
    check("parity_err", {63'd0, rx_parity_err}, {63'd0, ($countones(w) % 2) == 0});
    check("frame_err",  {63'd0, rx_frame_err},  {63'd0, !stop});
    check("overrun",    {63'd0, rx_overrun},    {63'd0, exp_ovr});
    check("busy_after", {63'd0, rx_busy},       {63'd0, !stop});
    @(negedge txclk);
  endtask

  task automatic ack_pulse();
    rx_data_ack = 1'b1;
    @(negedge txclk);
    rx_data_ack = 1'b0;
    m_valid = 1'b0;
    #1;
    check("valid_after_ack", {63'd0, rx_data_valid}, 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},   rx_data, 64'd0);
    check({tag, "_valid"},  {63'd0, rx_data_valid}, 64'd0);
    check({tag, "_perr"},   {63'd0, rx_parity_err}, 64'd0);
    check({tag, "_ferr"},   {63'd0, rx_frame_err},  64'd0);
    check({tag, "_ovr"},    {63'd0, rx_overrun},    64'd0);
    check({tag, "_busy"},   {63'd0, rx_busy},       64'd0);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] w2;
    logic        stop;
    logic        ack_ld;

    reset_n     = 1'b0;
    rx_in       = 1'b1;
    rx_enable   = 1'b1;
    rx_data_ack = 1'b0;
    repeat (3) @(negedge txclk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge txclk);

    // Clean frame, odd ones-count.
    send_frame(64'h8000_0000_0000_00FF, 1'b1);
    check_load(64'h8000_0000_0000_00FF, 1'b1, 1'b0);
    ack_pulse();

    // Even ones-count: parity error, word still delivered; ack leaves the flag.
    send_frame(64'h0000_0000_0000_0003, 1'b1);
    check_load(64'h0000_0000_0000_0003, 1'b1, 1'b0);
    ack_pulse();
    check("perr_held_after_ack", {63'd0, rx_parity_err}, 64'd1);
    repeat (3) @(negedge txclk);

    // One-cycle low glitch on an idle line.
    rx_in = 1'b0;
    @(negedge txclk);
    rx_in = 1'b1;
    @(posedge txclk);
    @(posedge txclk);
    #1;
    check("glitch_busy_high", {63'd0, rx_busy}, 64'd1);
    @(posedge txclk);
    #1;
    check("glitch_busy_drop", {63'd0, rx_busy}, 64'd0);
    repeat (6) @(negedge txclk);
    check("glitch_no_valid", {63'd0, rx_data_valid}, 64'd0);

    // Break: stop bit low and line held low for 300 cycles.
    w = {$urandom, $urandom};
    send_frame(w, 1'b0);
    rx_in = 1'b0;
    check_load(w, 1'b0, 1'b0);
    ack_pulse();
    repeat (300) @(negedge txclk);
    check("break_single_word", {63'd0, rx_data_valid}, 64'd0);
    check("break_busy",        {63'd0, rx_busy},       64'd1);
    check("break_ferr_held",   {63'd0, rx_frame_err},  64'd1);
    rx_in = 1'b1;
    repeat (4) @(negedge txclk);
    check("break_idle", {63'd0, rx_busy}, 64'd0);
    send_frame(64'h1, 1'b1);
    check_load(64'h1, 1'b1, 1'b0);
    ack_pulse();

    // Back-to-back frames, first without ack at the second load, then with it.
    for (int pass = 0; pass < 2; pass++) begin
      w  = {$urandom, $urandom};
      w2 = {$urandom, $urandom};
      fork
        begin
          send_frame(w, 1'b1);
          send_frame(w2, 1'b1);
        end
        begin
          repeat (132) @(negedge txclk);
          check_load(w, 1'b1, 1'b0);
        end
      join
      check_load(w2, 1'b1, pass[0]);
      repeat (3) @(negedge txclk);
    end

    // rx_enable low mid-idle: everything freezes, ack and line activity are lost.
    w = rx_data;
    rx_enable   = 1'b0;
    rx_data_ack = 1'b1;
    rx_in       = 1'b0;
    repeat (10) @(negedge txclk);
    check("freeze_valid", {63'd0, rx_data_valid}, 64'd1);
    check("freeze_busy",  {63'd0, rx_busy},       64'd0);
    rx_in       = 1'b1;
    rx_data_ack = 1'b0;
    @(negedge txclk);
    rx_enable = 1'b1;
    repeat (6) @(negedge txclk);
    check("thaw_busy",  {63'd0, rx_busy},       64'd0);
    check("thaw_valid", {63'd0, rx_data_valid}, 64'd1);
    check("thaw_data",  rx_data, w);

    // Reset asserted at bit 30 of a frame; the remaining bits are all ones.
    w = 64'hFFFF_FFFF_C000_0000;
    drive_bit(1'b0);
    for (int i = 0; i < 30; i++) drive_bit(w[i]);
    rx_in   = w[30];
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    m_valid = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge txclk);
    for (int i = 31; i < 64; i++) drive_bit(w[i]);
    drive_bit(1'b1);
    repeat (10) @(negedge txclk);
    check("midreset_no_word", {63'd0, rx_data_valid}, 64'd0);
    check("midreset_idle",    {63'd0, rx_busy},       64'd0);
    send_frame(64'hA000_0000_0000_0001, 1'b1);
    check_load(64'hA000_0000_0000_0001, 1'b1, 1'b0);

    // Random frames: random word, stop bit, ack timing and idle gaps.
    for (int n = 0; n < 24; n++) begin
      w      = {$urandom, $urandom};
      stop   = ($urandom_range(0, 4) != 0);
      ack_ld = $urandom_range(0, 1) != 0;
      send_frame(w, stop);
      check_load(w, stop, ack_ld);
      if ($urandom_range(0, 2) == 0) ack_pulse();
      repeat ($urandom_range(0, 7)) @(negedge txclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
